// File: rtl/oflow_mem_buffer_pkg.sv
// Shared definitions for the MEM buffer read path. The core FSMs and the
// buffer-side responder import these so that widths and state names stay aligned.
package oflow_mem_buffer_pkg;

  localparam int MEM_ADDR_LEN    = 8;
  localparam int MEM_DATA_LEN    = 64;
  // Line count carried alongside the buffer address (0..2**MEM_ADDR_LEN)
  localparam int REMAIN_BBOX_LEN = MEM_ADDR_LEN + 1;

  typedef enum logic [2:0] {
    idle_st,
    rd_st,
    wait_st,
    valid_st,
    done_st
  } rd_state_t;

endpackage

// File: rtl/oflow_mem_buffer_fsm_read.sv
// Buffer-side read responder: walks the MEM buffer one line per core
// acknowledge, presents each record to the PEs and pulses done_read at the end.
module oflow_mem_buffer_fsm_read
  import oflow_mem_buffer_pkg::*;
#(
  parameter int ADDR_LEN = MEM_ADDR_LEN,
  parameter int DATA_LEN = MEM_DATA_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_read,
  input  logic                read_new_line,
  input  logic [ADDR_LEN:0]   num_of_lines,
  output logic                mem_rd_en,
  output logic [ADDR_LEN-1:0] mem_addr,
  input  logic [DATA_LEN-1:0] mem_rd_data,
  output logic [DATA_LEN-1:0] data_out,
  output logic                data_valid,
  output logic                done_read,
  output logic                busy
);

  rd_state_t           state, next_state;
  logic [ADDR_LEN-1:0] last_line, last_line_d;
  logic [ADDR_LEN-1:0] mem_addr_d;
  logic                mem_rd_en_d;
  logic                data_valid_d;
  logic                done_read_d;
  logic                capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= idle_st;
      last_line  <= '0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      done_read  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      last_line  <= last_line_d;
      mem_addr   <= mem_addr_d;
      mem_rd_en  <= mem_rd_en_d;
      data_valid <= data_valid_d;
      done_read  <= done_read_d;
      busy       <= (next_state != idle_st);
      if (capture) begin
        data_out <= mem_rd_data;
      end
    end
  end

  // Register inputs are computed here so every output leaves a flop
  always_comb begin
    next_state   = state;
    last_line_d  = last_line;
    mem_addr_d   = mem_addr;
    mem_rd_en_d  = 1'b0;
    data_valid_d = data_valid;
    done_read_d  = 1'b0;
    capture      = 1'b0;

    case (state)
      idle_st: begin
        if (start_read) begin
          if (num_of_lines != '0) begin
            // num_of_lines = 2**ADDR_LEN truncates to 0, so last_line wraps to all-ones
            last_line_d = num_of_lines[ADDR_LEN-1:0] - ADDR_LEN'(1);
            mem_addr_d  = '0;
            mem_rd_en_d = 1'b1;
            next_state  = rd_st;
          end else begin
            done_read_d = 1'b1;
            next_state  = done_st;
          end
        end
      end

      rd_st: begin
        next_state = wait_st;
      end

      wait_st: begin
        capture      = 1'b1;
        data_valid_d = 1'b1;
        next_state   = valid_st;
      end

      valid_st: begin
        if (read_new_line) begin
          data_valid_d = 1'b0;
          if (mem_addr == last_line) begin
            done_read_d = 1'b1;
            next_state  = done_st;
          end else begin
            mem_addr_d  = mem_addr + ADDR_LEN'(1);
            mem_rd_en_d = 1'b1;
            next_state  = rd_st;
          end
        end
      end

      done_st: begin
        next_state = idle_st;
      end

      default: begin
        next_state = idle_st;
      end
    endcase
  end

endmodule
